// File: rtl/keypad_pkg.sv
// Shared types, default timing constants and small decode helpers for the
// keypad scanner/debouncer.
package keypad_pkg;

  localparam int unsigned DWELL_CYCLES_DEF    = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 20;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DEBOUNCE   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } kp_state_t;

  // True when exactly one bit of a 4-bit vector is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [1:0] low_idx4(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs, async active-low reset.
module sync2 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_debounce.sv
// 4x4 keypad row sweep with press/release debounce. Reports one key at a
// time: key_valid pulses once per accepted press, key_held covers the press
// and its release debounce.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES    = DWELL_CYCLES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  input  logic [3:0] cols,
  output logic       scan_en,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DW_W = $clog2(DWELL_CYCLES);
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  kp_state_t       state;
  logic [3:0]      scols;
  logic [DW_W-1:0] dwell_cnt;
  logic [DB_W-1:0] db_cnt;
  logic [1:0]      row_idx;
  logic [1:0]      col_idx;
  logic            cap_bit;

  sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cols),
    .q     (scols)
  );

  // Column of the key captured at the start of the debounce.
  assign cap_bit = scols[col_idx];

  // Sweep / debounce FSM; all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      dwell_cnt <= '0;
      db_cnt    <= '0;
      row_idx   <= '0;
      col_idx   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      scan_en   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      scan_en   <= 1'b0;
      unique case (state)
        SCAN: begin
          if (dwell_cnt == DW_LAST) begin
            dwell_cnt <= '0;
            if ((scols != 4'b0000) && is_onehot4(rows)) begin
              row_idx <= low_idx4(rows);
              col_idx <= low_idx4(scols);
              db_cnt  <= '0;
              state   <= DEBOUNCE;
            end else begin
              scan_en <= 1'b1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (cap_bit) begin
            if (db_cnt == DB_LAST) begin
              key_code  <= {row_idx, col_idx};
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              db_cnt    <= '0;
              state     <= PRESSED;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            db_cnt    <= '0;
            dwell_cnt <= '0;
            state     <= SCAN;
          end
        end
        PRESSED: begin
          if (!cap_bit) begin
            db_cnt <= '0;
            state  <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (cap_bit) begin
            db_cnt <= '0;
            state  <= PRESSED;
          end else if (db_cnt == DB_LAST) begin
            db_cnt    <= '0;
            dwell_cnt <= '0;
            key_held  <= 1'b0;
            state     <= SCAN;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
